// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V control FSM. Moore machine: control outputs are decoded
// from the next state and registered. pc_write_final is the one output that
// also depends on a live input (bcond). Reset blanks every write enable
// combinationally so an aborted instruction cannot commit anything.
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  output logic       pc_write_final,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted
);

  // Encodings 0..14 are used; anything above S_HALT is illegal.
  typedef enum logic [STATE_W-1:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_EX_M, S_MEM_R, S_MEM_W, S_WB_ALU,
    S_WB_LD, S_EX_B, S_PC4, S_JAL_WB, S_EX_JR, S_JR_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;
  } ctrl_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  // Per-state control word; anything not listed stays 0.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF:    begin c.mem_read = 1'b1; c.ir_write = 1'b1; end
      S_ID:    c.alu_src_b = 2'b10;
      S_EX_R:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_EX_I:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
      S_EX_M, S_EX_JR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_R: begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_W: begin
        c.mem_write = 1'b1; c.i_or_d = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1;
      end
      S_WB_ALU: begin c.reg_write = 1'b1; c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
      S_WB_LD: begin
        c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.alu_src_b = 2'b01; c.pc_write = 1'b1;
      end
      S_EX_B: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1;
      end
      S_PC4:   begin c.alu_src_b = 2'b01; c.pc_write = 1'b1; end
      S_JAL_WB, S_JR_WB: begin
        c.alu_src_b = 2'b01; c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
        c.pc_write = 1'b1; c.pc_source = 1'b1;
      end
      S_HALT:  c.is_halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d, ctrl;
  logic   legal;

  // Next-state logic and the control word that goes with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (opcode)
          OP_R:         state_d = S_EX_R;
          OP_I:         state_d = S_EX_I;
          OP_LD, OP_ST: state_d = S_EX_M;
          OP_BR:        state_d = S_EX_B;
          OP_JAL:       state_d = S_JAL_WB;
          OP_JALR:      state_d = S_EX_JR;
          OP_SYS:       state_d = halt_req ? S_HALT : S_PC4;
          default:      state_d = S_PC4;
        endcase
      end
      S_EX_R, S_EX_I: state_d = S_WB_ALU;
      S_EX_M:   state_d = (opcode == OP_LD) ? S_MEM_R : S_MEM_W;
      S_MEM_R:  state_d = S_WB_LD;
      S_EX_B:   state_d = bcond ? S_IF : S_PC4;
      S_EX_JR:  state_d = S_JR_WB;
      S_HALT:   state_d = S_HALT;
      S_MEM_W, S_WB_ALU, S_WB_LD, S_PC4, S_JAL_WB, S_JR_WB: state_d = S_IF;
      default:  state_d = S_IF;
    endcase
    ctrl_d = decode(state_d);
  end

  // State and registered control word; reset parks the machine in IF.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      ctrl_q  <= decode(S_IF);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // An upset into an unused encoding must not replay a stale control word.
  assign legal = (state_q <= S_HALT);
  assign ctrl  = legal ? ctrl_q : '0;

  assign pc_write_final = ~reset & (ctrl.pc_write | (ctrl.pc_write_cond & bcond));
  assign pc_source      = ctrl.pc_source;
  assign i_or_d         = ctrl.i_or_d;
  assign mem_read       = ~reset & ctrl.mem_read;
  assign mem_write      = ~reset & ctrl.mem_write;
  assign ir_write       = ~reset & ctrl.ir_write;
  assign reg_write      = ~reset & ctrl.reg_write;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b      = ctrl.alu_src_b;
  assign alu_op         = ctrl.alu_op;
  assign is_halted      = ~reset & ctrl.is_halted;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter STATE_W, default 4, state register width; no other parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from the instruction register.
REQ-005 bcond  input  1  branch-condition result from the ALU; valid only in EX_B.
REQ-006 halt_req  input  1  ecall halt condition (x17==10), sampled in ID.
REQ-007 pc_write_final  output  1  PC load enable for the PC register.
REQ-008 pc_source  output  1  next_pc select: 0 = live ALU result, 1 = ALUOut.
REQ-009 i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_read, mem_write, ir_write, reg_write  output  1 each  enables.
REQ-011 mem_to_reg  output  2  write-data select: 00 ALUOut, 01 MDR, 10 live ALU result.
REQ-012 alu_src_a  output  1  0 = PC, 1 = rs1 register A.
REQ-013 alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = immediate.
REQ-014 alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-015 is_halted  output  1  high only in HALT.

Function
REQ-016 Moore FSM: all outputs are a function of state only, except pc_write_final = pc_write | (pc_write_cond & bcond).
REQ-017 Unlisted outputs in a state are 0. pc_source and mem_to_reg are 0 unless stated.
REQ-018 IF: mem_read=1, ir_write=1, i_or_d=0. Next state is ID.
REQ-019 ID: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut <= PC+imm. Next state by opcode:
  - 0110011 -> EX_R
  - 0010011 -> EX_I
  - 0000011 or 0100011 -> EX_M
  - 1100011 -> EX_B
  - 1101111 -> JAL_WB
  - 1100111 -> EX_JR
  - 1110011 -> HALT if halt_req, otherwise PC4
  - any other opcode -> PC4 (executes as a NOP)
REQ-020 EX_R: a=1, b=00, op=10. EX_I: a=1, b=10, op=10. Both go to WB_ALU.
REQ-021 EX_M: a=1, b=10, op=00. Goes to MEM_R for opcode 0000011, otherwise MEM_W.
REQ-022 MEM_R: mem_read=1, i_or_d=1. Next state is WB_LD.
REQ-023 MEM_W: mem_write=1, i_or_d=1, a=0, b=01, op=00, pc_write=1, pc_source=0. Next state is IF.
REQ-024 WB_ALU: reg_write=1, mem_to_reg=00, a=0, b=01, op=00, pc_write=1, pc_source=0. Next state is IF.
REQ-025 WB_LD: same as WB_ALU except mem_to_reg=01. Next state is IF.
REQ-026 EX_B: a=1, b=00, op=01, pc_write_cond=1, pc_source=1. Next state is IF if bcond, otherwise PC4.
REQ-027 PC4: a=0, b=01, op=00, pc_write=1, pc_source=0. Next state is IF.
REQ-028 JAL_WB: a=0, b=01, op=00, reg_write=1, mem_to_reg=10, pc_write=1, pc_source=1. Next state is IF.
REQ-029 EX_JR: a=1, b=10, op=00. Next state is JR_WB.
REQ-030 JR_WB: identical outputs to JAL_WB. Next state is IF.
REQ-031 HALT: is_halted=1, all enables 0; stays in HALT until reset.
REQ-032 Instruction latency in cycles, IF to next IF:
  - R/I/JALR: 4
  - load: 5; store: 4
  - branch taken: 3; branch not taken: 4
  - JAL: 3; NOP/ecall-continue: 3
REQ-033 Exactly one pc_write_final pulse per non-halting instruction.
REQ-034 pc_write_final is never asserted in IF, ID, EX_R, EX_I, EX_M, MEM_R, EX_JR or HALT, regardless of bcond.
REQ-035 Unused state encodings go to IF on the next edge with all enables 0.

Reset
REQ-036 While reset=1, the state register loads IF on each rising clk edge.
REQ-037 While reset=1, pc_write_final, ir_write, reg_write, mem_write, mem_read and is_halted are forced to 0 combinationally.
REQ-038 The first cycle after reset deasserts is IF.
REQ-039 Reset asserted in any state, including HALT or mid-instruction, aborts the instruction with no further write enable.

Verification
REQ-040 Reset 2 cycles, then opcode=0110011 -> states IF, ID, EX_R, WB_ALU, IF; reg_write and pc_write_final=1 only in WB_ALU cycle 4.
REQ-041 opcode=0000011 -> IF, ID, EX_M, MEM_R, WB_LD; mem_read=1, i_or_d=1 in MEM_R; mem_to_reg=01, reg_write=1 in WB_LD.
REQ-042 opcode=1100011 with bcond=1 in EX_B -> pc_write_final=1 with pc_source=1, then IF. With bcond=0 -> EX_B has pc_write_final=0, then PC4 has pc_write_final=1, pc_source=0.
REQ-043 Toggle bcond=1 during every state of an R-type instruction -> pc_write_final pattern unchanged (single pulse, WB_ALU only).
REQ-044 opcode=1110011 with halt_req=1 -> is_halted=1 from cycle 3 and stays 1 for 20+ cycles with no enables. Then reset=1 -> is_halted=0 and state IF.
REQ-045 Assert reset during MEM_W -> mem_write and pc_write_final=0 in that cycle; IF follows reset release.
